crypto_accel_axi: RTL and testbench

CRYPTO_ACCEL_AXI -- requirements
Module: crypto_accel_axi

---
 rtl/crypto_accel_axi.sv | 202 ++++++++++++++++++++
 tb/tb_crypto_accel_axi.sv | 513 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/crypto_accel_axi.sv
// Register front-end for an AES-CTR engine: a single-outstanding bus slave that
// exposes key/counter registers and streams 128-bit blocks into and out of the AES FIFOs.
// state | meaning
// IDLE  | accepting a write or read address (write wins)
// WDATA | waiting for write data, register update on handshake
// WRESP | presenting OKAY write response
// RDATA | presenting read data captured at address acceptance
module crypto_accel_axi #(
  parameter int ADDR_W = 38
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wraddr_valid,
  output logic              wraddr_ready,
  input  logic [ADDR_W-1:0] wraddr,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [31:0]       wr_dat,
  output logic              wrresp_valid,
  input  logic              wrresp_ready,
  output logic [1:0]        wrresp_dat,
  input  logic              rdaddr_valid,
  output logic              rdaddr_ready,
  input  logic [ADDR_W-1:0] rdaddr,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [31:0]       rd_dat,
  output logic [1:0]        rdresp_dat,
  output logic [255:0]      aes_key,
  output logic [127:0]      aes_ctr,
  output logic              aes_in_valid,
  input  logic              aes_in_ready,
  output logic [127:0]      aes_in_block,
  input  logic              aes_out_valid,
  output logic              aes_out_ready,
  input  logic [127:0]      aes_out_block,
  input  logic              aes_fifo_empty,
  output logic              aes_rst
);

  typedef enum logic [1:0] {IDLE, WDATA, WRESP, RDATA} state_t;

  state_t      state, state_nxt;
  logic [7:0]  addr_q;
  logic        auto_inc;
  logic [1:0]  in_cnt;
  logic [1:0]  out_idx;
  logic        rd_pop_q;
  logic [7:0]  rd_sel;
  logic [31:0] rd_mux;
  logic [31:0] out_word;
  logic        busy;
  logic        wr_addr_hs, rd_addr_hs, wr_hs, rd_hs, in_hs;
  logic        wr_ctrl, soft_rst, wr_din, wr_ctr_any;
  logic        unused_addr_bits;

  function automatic logic [31:0] bswap(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  assign unused_addr_bits = ^{wraddr[ADDR_W-1:8], rdaddr[ADDR_W-1:8]};

  // Every access completes with OKAY, so response codes are constant.
  assign wrresp_dat = 2'b00;
  assign rdresp_dat = 2'b00;

  always_comb begin
    state_nxt    = state;
    wraddr_ready = 1'b0;
    rdaddr_ready = 1'b0;
    wr_ready     = 1'b0;
    wrresp_valid = 1'b0;
    rd_valid     = 1'b0;
    case (state)
      IDLE: begin
        wraddr_ready = 1'b1;
        rdaddr_ready = 1'b1;
        if (wraddr_valid)      state_nxt = WDATA;
        else if (rdaddr_valid) state_nxt = RDATA;
      end
      WDATA: begin
        wr_ready = 1'b1;
        if (wr_valid) state_nxt = WRESP;
      end
      WRESP: begin
        wrresp_valid = 1'b1;
        if (wrresp_ready) state_nxt = IDLE;
      end
      RDATA: begin
        rd_valid = 1'b1;
        if (rd_ready) state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  assign wr_addr_hs = (state == IDLE) && wraddr_valid;
  assign rd_addr_hs = (state == IDLE) && rdaddr_valid && !wraddr_valid;
  assign wr_hs      = (state == WDATA) && wr_valid;
  assign rd_hs      = (state == RDATA) && rd_ready;
  assign in_hs      = aes_in_valid && aes_in_ready;

  assign wr_ctrl    = wr_hs && (addr_q == 8'h00);
  assign soft_rst   = wr_ctrl && wr_dat[31];
  assign wr_din     = wr_hs && (addr_q == 8'h04);
  assign wr_ctr_any = wr_hs && (addr_q[7:4] == 4'h1) && (addr_q[1:0] == 2'b00);

  assign busy   = aes_in_valid | ~aes_fifo_empty | (in_cnt != 2'd0);
  assign rd_sel = rdaddr[7:0];

  always_comb begin
    out_word = aes_out_block[127:96];
    case (out_idx)
      2'd0: out_word = aes_out_block[127:96];
      2'd1: out_word = aes_out_block[95:64];
      2'd2: out_word = aes_out_block[63:32];
      2'd3: out_word = aes_out_block[31:0];
    endcase
  end

  always_comb begin
    rd_mux = 32'd0;
    if (rd_sel == 8'h00)
      rd_mux = {29'd0, ~aes_in_ready, ~aes_out_valid, busy};
    else if ((rd_sel == 8'h08) && aes_out_valid)
      rd_mux = bswap(out_word);
    for (int i = 0; i < 4; i++)
      if (rd_sel == 8'(16 + 4*i)) rd_mux = aes_ctr[(3-i)*32 +: 32];
    for (int i = 0; i < 8; i++)
      if (rd_sel == 8'(32 + 4*i)) rd_mux = aes_key[(7-i)*32 +: 32];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q        <= 8'd0;
      aes_key       <= '0;
      aes_ctr       <= '0;
      auto_inc      <= 1'b0;
      in_cnt        <= 2'd0;
      out_idx       <= 2'd0;
      aes_in_block  <= '0;
      aes_in_valid  <= 1'b0;
      aes_out_ready <= 1'b0;
      rd_dat        <= 32'd0;
      rd_pop_q      <= 1'b0;
      aes_rst       <= 1'b1;
    end else begin
      aes_rst       <= soft_rst;
      aes_out_ready <= 1'b0;

      if (wr_addr_hs) addr_q <= wraddr[7:0];
      if (rd_addr_hs) begin
        addr_q   <= rd_sel;
        rd_dat   <= rd_mux;
        rd_pop_q <= (rd_sel == 8'h08) && aes_out_valid;
      end

      // A counter register write in the same cycle wins over auto-increment.
      if (in_hs) begin
        aes_in_valid <= 1'b0;
        if (auto_inc && !wr_ctr_any) aes_ctr <= aes_ctr + 128'd1;
      end

      if (wr_din && !aes_in_valid) begin
        case (in_cnt)
          2'd0: aes_in_block[127:96] <= bswap(wr_dat);
          2'd1: aes_in_block[95:64]  <= bswap(wr_dat);
          2'd2: aes_in_block[63:32]  <= bswap(wr_dat);
          2'd3: aes_in_block[31:0]   <= bswap(wr_dat);
        endcase
        in_cnt <= in_cnt + 2'd1;
        if (in_cnt == 2'd3) aes_in_valid <= 1'b1;
      end

      for (int i = 0; i < 4; i++)
        if (wr_hs && (addr_q == 8'(16 + 4*i))) aes_ctr[(3-i)*32 +: 32] <= wr_dat;
      for (int i = 0; i < 8; i++)
        if (wr_hs && (addr_q == 8'(32 + 4*i))) aes_key[(7-i)*32 +: 32] <= wr_dat;

      if (rd_hs && rd_pop_q) begin
        out_idx <= out_idx + 2'd1;
        if (out_idx == 2'd3) aes_out_ready <= 1'b1;
      end

      if (wr_ctrl) begin
        auto_inc <= wr_dat[30];
        if (wr_dat[31]) begin
          aes_ctr      <= '0;
          in_cnt       <= 2'd0;
          out_idx      <= 2'd0;
          aes_in_valid <= 1'b0;
          aes_in_block <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_crypto_accel_axi.sv
// Testbench for crypto_accel_axi: directed scenarios plus randomized register and
// block traffic checked against a word-level model of the register map and FIFOs.
module tb_crypto_accel_axi;
  localparam int ADDR_W = 38;

  logic clk = 1'b0;
  logic rst_n;
  logic wraddr_valid, wraddr_ready, wr_valid, wr_ready, wrresp_valid, wrresp_ready;
  logic rdaddr_valid, rdaddr_ready, rd_valid, rd_ready;
  logic [ADDR_W-1:0] wraddr, rdaddr;
  logic [31:0] wr_dat, rd_dat;
  logic [1:0] wrresp_dat, rdresp_dat;
  logic [255:0] aes_key;
  logic [127:0] aes_ctr, aes_in_block, aes_out_block;
  logic aes_in_valid, aes_in_ready, aes_out_valid, aes_out_ready, aes_fifo_empty, aes_rst;

  always #5 clk = ~clk;

  crypto_accel_axi #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .wraddr_valid(wraddr_valid), .wraddr_ready(wraddr_ready), .wraddr(wraddr),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_dat(wr_dat),
    .wrresp_valid(wrresp_valid), .wrresp_ready(wrresp_ready), .wrresp_dat(wrresp_dat),
    .rdaddr_valid(rdaddr_valid), .rdaddr_ready(rdaddr_ready), .rdaddr(rdaddr),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_dat(rd_dat), .rdresp_dat(rdresp_dat),
    .aes_key(aes_key), .aes_ctr(aes_ctr),
    .aes_in_valid(aes_in_valid), .aes_in_ready(aes_in_ready), .aes_in_block(aes_in_block),
    .aes_out_valid(aes_out_valid), .aes_out_ready(aes_out_ready), .aes_out_block(aes_out_block),
    .aes_fifo_empty(aes_fifo_empty), .aes_rst(aes_rst)
  );

  int total = 0;
  int bad = 0;
  int pop_cnt = 0;
  int rst_cnt = 0;

  always @(posedge clk) begin
    if (aes_out_ready) pop_cnt++;
    if (rst_n && aes_rst) rst_cnt++;
  end

  // Reference model
  logic [31:0]  key_m [8];
  logic [127:0] ctr_m;
  bit           auto_m;
  logic [31:0]  words_m [$];
  bit           in_valid_m;
  logic [127:0] blk_m;
  int           out_idx_m;

  function automatic logic [31:0] bswap(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  function automatic logic [255:0] key_flat();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[255-32*i -: 32] = key_m[i];
    return r;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 8; i++) key_m[i] = 32'd0;
    ctr_m = '0; auto_m = 0; words_m.delete(); in_valid_m = 0; blk_m = '0; out_idx_m = 0;
  endfunction

  function automatic void model_din(input logic [31:0] d);
    if (!in_valid_m) begin
      words_m.push_back(bswap(d));
      if (words_m.size() == 4) begin
        blk_m = {words_m[0], words_m[1], words_m[2], words_m[3]};
        in_valid_m = 1;
        words_m.delete();
      end
    end
  endfunction

  function automatic logic sig(input int w);
    case (w)
      0: return wraddr_ready;
      1: return wr_ready;
      2: return wrresp_valid;
      3: return rdaddr_ready;
      default: return rd_valid;
    endcase
  endfunction

  task automatic wait_hi(input int which, input string nm);
    int n = 0;
    while (!sig(which) && n < 8) begin
      @(negedge clk);
      n++;
    end
    if (n == 8) begin
      total++; bad++;
      $display("FAIL timeout_%s got=0 want=1", nm);
    end
  endtask

  task automatic bus_write(input logic [7:0] a, input logic [31:0] d, input bit acc,
                           output logic [1:0] resp);
    @(negedge clk);
    wraddr = ADDR_W'({$urandom(), $urandom()});
    wraddr[7:0] = a;
    wraddr_valid = 1'b1;
    wait_hi(0, "wraddr_ready");
    @(posedge clk); #1 wraddr_valid = 1'b0;
    wr_dat = d; wr_valid = 1'b1;
    if (acc) aes_in_ready = 1'b1;
    wait_hi(1, "wr_ready");
    @(posedge clk); #1 wr_valid = 1'b0;
    if (acc) aes_in_ready = 1'b0;
    wrresp_ready = 1'b1;
    wait_hi(2, "wrresp_valid");
    resp = wrresp_dat;
    @(posedge clk); #1 wrresp_ready = 1'b0;
  endtask

  task automatic bus_read(input logic [7:0] a, output logic [31:0] d, output logic [1:0] resp,
                          output logic pop);
    @(negedge clk);
    rdaddr = ADDR_W'({$urandom(), $urandom()});
    rdaddr[7:0] = a;
    rdaddr_valid = 1'b1;
    wait_hi(3, "rdaddr_ready");
    @(posedge clk); #1 rdaddr_valid = 1'b0;
    rd_ready = 1'b1;
    wait_hi(4, "rd_valid");
    d = rd_dat; resp = rdresp_dat;
    @(posedge clk); #1 rd_ready = 1'b0;
    pop = aes_out_ready;
  endtask

  task automatic accept_block();
    @(negedge clk); aes_in_ready = 1'b1;
    @(posedge clk); #1 aes_in_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    if (aes_rst !== 1'b1) begin bad++; $display("FAIL rst_aes_rst got=%0b want=1", aes_rst); end
    total++;
    if ({wraddr_ready, rdaddr_ready, wr_ready, wrresp_valid, rd_valid} !== 5'b11000) begin
      bad++; $display("FAIL rst_handshakes got=%b want=11000",
                      {wraddr_ready, rdaddr_ready, wr_ready, wrresp_valid, rd_valid});
    end
    total++;
    if ({aes_in_valid, aes_out_ready} !== 2'b00) begin
      bad++; $display("FAIL rst_aes_valids got=%b want=00", {aes_in_valid, aes_out_ready});
    end
    total++;
    if (aes_key !== 256'd0 || aes_ctr !== 128'd0) begin
      bad++; $display("FAIL rst_key_ctr got=%h/%h want=0", aes_key, aes_ctr);
    end
    total++;
    if (rd_dat !== 32'd0 || wrresp_dat !== 2'd0 || rdresp_dat !== 2'd0) begin
      bad++; $display("FAIL rst_rd_resp got=%h/%0d/%0d want=0", rd_dat, wrresp_dat, rdresp_dat);
    end
    total++;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    if (aes_rst !== 1'b0) begin bad++; $display("FAIL rst_release got=%0b want=0", aes_rst); end
    total++;
    model_reset();
  endtask

  task automatic test_ctrl_write();
    logic [31:0] d; logic [1:0] r; logic p;
    @(negedge clk);
    wraddr = '0; wraddr_valid = 1'b1;
    @(posedge clk); #1 wraddr_valid = 1'b0;
    if (wr_ready !== 1'b1) begin bad++; $display("FAIL ctrl_wr_ready got=%0b want=1", wr_ready); end
    total++;
    wr_dat = 32'h4000_0000; wr_valid = 1'b1;
    @(posedge clk); #1 wr_valid = 1'b0;
    if (wrresp_valid !== 1'b1 || wrresp_dat !== 2'b00 || wr_ready !== 1'b0) begin
      bad++; $display("FAIL ctrl_wresp got=%0b/%0d want=1/0", wrresp_valid, wrresp_dat);
    end
    total++;
    wrresp_ready = 1'b1;
    @(posedge clk); #1 wrresp_ready = 1'b0;
    if (wraddr_ready !== 1'b1 || wrresp_valid !== 1'b0) begin
      bad++; $display("FAIL ctrl_idle got=%0b want=1", wraddr_ready);
    end
    total++;
    auto_m = 1;
    aes_in_ready = 1'b1;
    bus_read(8'h00, d, r, p);
    aes_in_ready = 1'b0;
    if (d !== 32'h0000_0002 || r !== 2'b00) begin
      bad++; $display("FAIL ctrl_status got=%h/%0d want=00000002/0", d, r);
    end
    total++;
  endtask

  task automatic test_data_in();
    logic [31:0] w [4];
    logic [31:0] d; logic [1:0] r; logic p;
    w[0] = 32'h1122_3344; w[1] = 32'h5566_7788; w[2] = 32'h99AA_BBCC; w[3] = 32'hDDEE_FF00;
    for (int i = 0; i < 4; i++) begin
      bus_write(8'h04, w[i], 0, r);
      if (i == 2 && aes_in_valid !== 1'b0) begin
        bad++; $display("FAIL din_early_valid got=%0b want=0", aes_in_valid);
      end
      if (i == 2) total++;
    end
    if (aes_in_valid !== 1'b1 || aes_in_block !== 128'h4433_2211_8877_6655_CCBB_AA99_00FF_EEDD) begin
      bad++; $display("FAIL din_block got=%0b/%h want=1/4433221188776655ccbbaa9900ffeedd",
                      aes_in_valid, aes_in_block);
    end
    total++;
    bus_read(8'h00, d, r, p);
    if (d !== 32'h7) begin bad++; $display("FAIL din_busy_status got=%h want=00000007", d); end
    total++;
    bus_write(8'h04, 32'hDEAD_BEEF, 0, r);
    if (r !== 2'b00 || aes_in_block !== 128'h4433_2211_8877_6655_CCBB_AA99_00FF_EEDD) begin
      bad++; $display("FAIL din_drop got=%0d/%h want=0/unchanged", r, aes_in_block);
    end
    total++;
    accept_block();
    if (aes_in_valid !== 1'b0 || aes_ctr !== 128'd1) begin
      bad++; $display("FAIL din_accept got=%0b/%h want=0/1", aes_in_valid, aes_ctr);
    end
    total++;
  endtask

  task automatic test_data_out();
    logic [31:0] exp [4];
    logic [31:0] d; logic [1:0] r; logic p; int p0;
    exp[0] = 32'h6745_2301; exp[1] = 32'hEFCD_AB89; exp[2] = 32'h3322_1100; exp[3] = 32'h7766_5544;
    aes_out_block = 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677;
    aes_out_valid = 1'b1;
    p0 = pop_cnt;
    for (int i = 0; i < 4; i++) begin
      bus_read(8'h08, d, r, p);
      if (d !== exp[i] || r !== 2'b00) begin
        bad++; $display("FAIL dout_word%0d got=%h/%0d want=%h/0", i, d, r, exp[i]);
      end
      total++;
      if (i == 2 && pop_cnt != p0) begin
        bad++; $display("FAIL dout_early_pop got=%0d want=%0d", pop_cnt, p0);
      end
      if (i == 2) total++;
    end
    repeat (2) @(posedge clk);
    #1;
    if (pop_cnt != p0 + 1) begin
      bad++; $display("FAIL dout_pop_once got=%0d want=%0d", pop_cnt - p0, 1);
    end
    total++;
    aes_out_valid = 1'b0;
  endtask

  task automatic test_out_empty();
    logic [31:0] d; logic [1:0] r; logic p; int p0;
    aes_out_valid = 1'b0;
    p0 = pop_cnt;
    bus_read(8'h08, d, r, p);
    repeat (2) @(posedge clk);
    #1;
    if (d !== 32'd0 || r !== 2'b00 || pop_cnt != p0) begin
      bad++; $display("FAIL dout_empty got=%h/%0d/%0d want=0/0/0", d, r, pop_cnt - p0);
    end
    total++;
    aes_out_block = 128'hA1B2_C3D4_0000_0000_0000_0000_0000_0000;
    aes_out_valid = 1'b1;
    bus_read(8'h08, d, r, p);
    if (d !== 32'hD4C3_B2A1) begin bad++; $display("FAIL dout_no_advance got=%h want=d4c3b2a1", d); end
    total++;
  endtask

  task automatic test_soft_reset();
    logic [31:0] d; logic [1:0] r; logic p; int r0;
    for (int i = 0; i < 8; i++) begin
      key_m[i] = $urandom();
      bus_write(8'(32 + 4*i), key_m[i], 0, r);
    end
    for (int i = 0; i < 3; i++) bus_write(8'(16 + 4*i), 32'd0, 0, r);
    bus_write(8'h1C, 32'd2, 0, r);
    if (aes_ctr !== 128'd2) begin bad++; $display("FAIL srst_ctr_pre got=%h want=2", aes_ctr); end
    total++;
    bus_write(8'h04, 32'hFFFF_FFFF, 0, r);
    bus_write(8'h04, 32'hEEEE_EEEE, 0, r);
    r0 = rst_cnt;
    bus_write(8'h00, 32'h8000_0000, 0, r);
    repeat (2) @(posedge clk);
    #1;
    if (rst_cnt - r0 != 1 || aes_rst !== 1'b0) begin
      bad++; $display("FAIL srst_pulse got=%0d want=1", rst_cnt - r0);
    end
    total++;
    if (aes_ctr !== 128'd0 || aes_key !== key_flat()) begin
      bad++; $display("FAIL srst_ctr_key got=%h/%h want=0/%h", aes_ctr, aes_key, key_flat());
    end
    total++;
    bus_write(8'h04, 32'h0102_0304, 0, r);
    bus_write(8'h04, 32'h0506_0708, 0, r);
    bus_write(8'h04, 32'h090A_0B0C, 0, r);
    bus_write(8'h04, 32'h0D0E_0F10, 0, r);
    if (aes_in_block !== 128'h0403_0201_0807_0605_0C0B_0A09_100F_0E0D || aes_in_valid !== 1'b1) begin
      bad++; $display("FAIL srst_word_count got=%h want=04030201080706050c0b0a09100f0e0d", aes_in_block);
    end
    total++;
    accept_block();
    if (aes_ctr !== 128'd0) begin bad++; $display("FAIL srst_auto_clear got=%h want=0", aes_ctr); end
    total++;
    bus_read(8'h08, d, r, p);
    if (d !== 32'hD4C3_B2A1) begin bad++; $display("FAIL srst_out_idx got=%h want=d4c3b2a1", d); end
    total++;
    aes_out_valid = 1'b0;
  endtask

  task automatic test_ctr_write();
    logic [31:0] d; logic [1:0] r; logic p;
    for (int i = 0; i < 3; i++) bus_write(8'(16 + 4*i), 32'd0, 0, r);
    bus_write(8'h1C, 32'h0000_0001, 0, r);
    if (aes_ctr !== 128'h1) begin bad++; $display("FAIL ctr_write got=%h want=1", aes_ctr); end
    total++;
    bus_write(8'h10, 32'h1234_5678, 0, r);
    bus_read(8'h10, d, r, p);
    if (d !== 32'h1234_5678 || aes_ctr[127:96] !== 32'h1234_5678) begin
      bad++; $display("FAIL ctr_readback got=%h want=12345678", d);
    end
    total++;
  endtask

  task automatic test_ctr_priority();
    logic [1:0] r;
    bus_write(8'h00, 32'h4000_0000, 0, r);
    bus_write(8'h10, 32'hA5A5_A5A5, 0, r);
    bus_write(8'h14, 32'h5A5A_5A5A, 0, r);
    bus_write(8'h18, 32'h0000_0000, 0, r);
    bus_write(8'h1C, 32'hFFFF_FFFF, 0, r);
    for (int i = 0; i < 4; i++) bus_write(8'h04, $urandom(), 0, r);
    bus_write(8'h18, 32'h1234_5678, 1, r);
    if (aes_ctr !== 128'hA5A5_A5A5_5A5A_5A5A_1234_5678_FFFF_FFFF || aes_in_valid !== 1'b0) begin
      bad++; $display("FAIL ctr_priority got=%h want=a5a5a5a55a5a5a5a12345678ffffffff", aes_ctr);
    end
    total++;
    for (int i = 0; i < 4; i++) bus_write(8'(16 + 4*i), 32'hFFFF_FFFF, 0, r);
    for (int i = 0; i < 4; i++) bus_write(8'h04, $urandom(), 0, r);
    accept_block();
    if (aes_ctr !== 128'd0) begin bad++; $display("FAIL ctr_wrap got=%h want=0", aes_ctr); end
    total++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    d = $urandom();
    @(negedge clk);
    wraddr = ADDR_W'({$urandom(), $urandom()}); wraddr[7:0] = 8'h24;
    rdaddr = ADDR_W'({$urandom(), $urandom()}); rdaddr[7:0] = 8'h24;
    wraddr_valid = 1'b1; rdaddr_valid = 1'b1;
    @(posedge clk); #1 wraddr_valid = 1'b0;
    if (wr_ready !== 1'b1 || rd_valid !== 1'b0) begin
      bad++; $display("FAIL b2b_write_wins got=%0b/%0b want=1/0", wr_ready, rd_valid);
    end
    total++;
    wr_dat = d; wr_valid = 1'b1;
    @(posedge clk); #1 wr_valid = 1'b0; wrresp_ready = 1'b1;
    @(posedge clk); #1 wrresp_ready = 1'b0;
    @(posedge clk); #1 rdaddr_valid = 1'b0;
    if (rd_valid !== 1'b1 || rd_dat !== d) begin
      bad++; $display("FAIL b2b_read got=%0b/%h want=1/%h", rd_valid, rd_dat, d);
    end
    total++;
    rd_ready = 1'b1;
    @(posedge clk); #1 rd_ready = 1'b0;
    if (rdaddr_ready !== 1'b1) begin bad++; $display("FAIL b2b_idle got=%0b want=1", rdaddr_ready); end
    total++;
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    wraddr = ADDR_W'(8'h20); wraddr_valid = 1'b1;
    @(posedge clk); #1 wraddr_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    if (wraddr_ready !== 1'b1 || wr_ready !== 1'b0 || aes_rst !== 1'b1 || aes_key !== 256'd0) begin
      bad++; $display("FAIL reset_mid got=%0b%0b%0b want=101", wraddr_ready, wr_ready, aes_rst);
    end
    total++;
    aes_out_valid = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    model_reset();
  endtask

  task automatic test_random();
    logic [31:0] d, exp; logic [1:0] r; logic p; logic [7:0] a;
    int op, k;
    bit b30, b31, pop_exp;
    for (int it = 0; it < 300; it++) begin
      op = $urandom_range(0, 7);
      d = $urandom();
      case (op)
        0: begin
          k = $urandom_range(0, 7);
          bus_write(8'(32 + 4*k), d, 0, r);
          key_m[k] = d;
        end
        1: begin
          k = $urandom_range(0, 3);
          bus_write(8'(16 + 4*k), d, 0, r);
          ctr_m[127-32*k -: 32] = d;
        end
        2: begin
          k = $urandom_range(0, 12);
          aes_fifo_empty = ($urandom_range(0, 3) != 0);
          if (!in_valid_m) aes_in_ready = ($urandom_range(0, 1) == 1);
          if (k < 8) begin a = 8'(32 + 4*k); exp = key_m[k]; end
          else if (k < 12) begin a = 8'(16 + 4*(k-8)); exp = ctr_m[127-32*(k-8) -: 32]; end
          else begin
            a = 8'h00;
            exp = {29'd0, ~aes_in_ready, ~aes_out_valid,
                   in_valid_m | ~aes_fifo_empty | (words_m.size() != 0)};
          end
          bus_read(a, d, r, p);
          aes_in_ready = 1'b0;
          if (d !== exp || r !== 2'b00) begin
            bad++; $display("FAIL rnd_read a=%h got=%h want=%h", a, d, exp);
          end
          total++;
        end
        3: begin
          bus_write(8'h04, d, 0, r);
          model_din(d);
        end
        4: begin
          if (in_valid_m) begin
            accept_block();
            in_valid_m = 0;
            if (auto_m) ctr_m = ctr_m + 128'd1;
          end else @(posedge clk);
        end
        5: begin
          b31 = ($urandom_range(0, 5) == 0);
          b30 = ($urandom_range(0, 1) == 1);
          bus_write(8'h00, {b31, b30, d[29:0]}, 0, r);
          auto_m = b30;
          if (b31) begin ctr_m = '0; words_m.delete(); in_valid_m = 0; out_idx_m = 0; end
        end
        6: begin
          a = ($urandom_range(0, 3) == 0) ? 8'h04 : 8'($urandom_range(64, 255));
          if (a != 8'h04) bus_write(a, d, 0, r);
          bus_read(a, d, r, p);
          if (d !== 32'd0 || r !== 2'b00) begin
            bad++; $display("FAIL rnd_unmapped a=%h got=%h want=0", a, d);
          end
          total++;
        end
        default: begin
          if (!aes_out_valid && $urandom_range(0, 1) == 1) begin
            aes_out_block = {$urandom(), $urandom(), $urandom(), $urandom()};
            aes_out_valid = 1'b1;
          end
          pop_exp = 0;
          if (aes_out_valid) begin
            exp = bswap(aes_out_block[127-32*out_idx_m -: 32]);
            out_idx_m++;
            if (out_idx_m == 4) begin out_idx_m = 0; pop_exp = 1; end
          end else exp = 32'd0;
          bus_read(8'h08, d, r, p);
          if (d !== exp || p !== pop_exp) begin
            bad++; $display("FAIL rnd_dout got=%h/%0b want=%h/%0b", d, p, exp, pop_exp);
          end
          total++;
          if (pop_exp) begin
            @(posedge clk); #1;
            aes_out_valid = ($urandom_range(0, 1) == 1);
            aes_out_block = {$urandom(), $urandom(), $urandom(), $urandom()};
          end
        end
      endcase
      if (aes_ctr !== ctr_m || aes_key !== key_flat()) begin
        bad++; $display("FAIL rnd_regs op=%0d got=%h want=%h", op, aes_ctr, ctr_m);
      end
      total++;
      if (aes_in_valid !== in_valid_m || (in_valid_m && aes_in_block !== blk_m)) begin
        bad++; $display("FAIL rnd_in_block op=%0d got=%0b/%h want=%0b/%h",
                        op, aes_in_valid, aes_in_block, in_valid_m, blk_m);
      end
      total++;
    end
  endtask

  initial begin
    wraddr_valid = 0; wraddr = '0; wr_valid = 0; wr_dat = '0; wrresp_ready = 0;
    rdaddr_valid = 0; rdaddr = '0; rd_ready = 0;
    aes_in_ready = 0; aes_out_valid = 0; aes_out_block = '0; aes_fifo_empty = 1;
    test_reset();
    test_ctrl_write();
    test_data_in();
    test_data_out();
    test_out_empty();
    test_soft_reset();
    test_ctr_write();
    test_ctr_priority();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=running want=finished");
    $fatal(1);
  end

endmodule
